rename_ctrl: RTL and testbench

//  Rename-stage controller: owns the RAT (aliases + done bits) and the physical-tag free list, and drives rename_decoder.

---
 rtl/rename_ctrl_pkg.sv | 38 +++
 rtl/rename_ctrl_fifo.sv | 100 ++++++++++
 rtl/rename_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_rename_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rename_ctrl_pkg
//   Shared definitions for the rename-stage controller: widths, the null tag,
//   FSM state encodings and the reset alias mapping (arch i -> tag i+1).
//   No ports; imported by rename_ctrl and free_list_fifo.
// -----------------------------------------------------------------------------
package rename_ctrl_pkg;

  localparam int NUM_ARCH = 10;
  localparam int ARCH_W   = 4;
  localparam int NUM_PHYS = 32;
  localparam int TAG_W    = 5;
  localparam int MOP_W    = 24;
  localparam int NUM_SRC  = 4;
  localparam int IMM_W    = 4;
  localparam int PTR_W    = 5;
  localparam int CNT_W    = 6;

  // Tag 0 means "no register"; it is never allocated or broadcast.
  localparam logic [TAG_W-1:0] NULL_TAG       = 5'd0;
  // Tags 1..NUM_ARCH are the reset aliases; the rest seed the free list.
  localparam logic [TAG_W-1:0] FIRST_FREE_TAG = TAG_W'(NUM_ARCH + 1);
  localparam logic [TAG_W-1:0] LAST_TAG       = TAG_W'(NUM_PHYS - 1);
  // A push at this occupancy would leave no room to tell full from empty.
  localparam logic [CNT_W-1:0] FULL_COUNT     = CNT_W'(NUM_PHYS - 1);
  localparam logic [CNT_W-1:0] EMPTY_COUNT    = 6'd0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reset mapping of architectural register idx to its physical tag.
  function automatic logic [TAG_W-1:0] reset_alias(input int idx);
    return TAG_W'(idx + 1);
  endfunction

endpackage

// File: rtl/rename_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// free_list_fifo
//   Circular FIFO of free physical tags. 32 entries, 5-bit wrapping head/tail,
//   6-bit occupancy. Push and pop in the same cycle leave the count unchanged.
//   There is no push-to-pop bypass: a tag pushed into an empty list becomes
//   visible at head_tag one cycle later. Pushes of the null tag or at
//   occupancy NUM_PHYS-1 are dropped (and flagged by free_list_fifo_chk).
// Ports
//   clk, rst        clock, synchronous active-high reset (empties the list)
//   push, push_tag  tag returned to the list
//   pop             consume head_tag (ignored when empty)
//   head_tag        oldest free tag (valid when count != 0)
//   count           number of free tags held
// -----------------------------------------------------------------------------
module free_list_fifo
  import rename_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem_r [NUM_PHYS];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against occupancy and the null tag.
  always_comb begin
    push_ok_s = push & (count != FULL_COUNT) & (push_tag != NULL_TAG);
    pop_ok_s  = pop & (count != EMPTY_COUNT);
  end

  // Tag storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= push_tag;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= 5'd0;
      tail_r <= 5'd0;
      count  <= 6'd0;
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + 5'd1;
      end
      if (pop_ok_s) begin
        head_r <= head_r + 5'd1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_tag = mem_r[head_r];

  free_list_fifo_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .count    (count)
  );

endmodule

// -----------------------------------------------------------------------------
// free_list_fifo_chk
//   Simulation-only protocol checker for free_list_fifo pushes.
// -----------------------------------------------------------------------------
module free_list_fifo_chk
  import rename_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic [TAG_W-1:0] push_tag,
  input logic [CNT_W-1:0] count
);

  // Flag pushes that the FIFO will silently drop.
  always @(posedge clk) begin
    if (!rst && push && ((count == FULL_COUNT) || (push_tag == NULL_TAG))) begin
      $error("free list push dropped: tag %0d count %0d", push_tag, count);
    end
  end

endmodule

// File: rtl/rename_ctrl.sv
// -----------------------------------------------------------------------------
// rename_ctrl
//   Rename-stage controller. Owns the RAT (alias tag + done bit per arch reg)
//   and the physical-tag free list, feeds the external rename_decoder and
//   presents renamed ops through one registered output stage.
//   After reset the controller spends NUM_PHYS-NUM_ARCH-1 cycles in INIT
//   seeding the free list with tags NUM_ARCH+1..NUM_PHYS-1, then enters RUN.
// Configuration
//   RENAME_BYPASS_EN  when defined, dec_rat_done also reflects this cycle's
//                     CDB match; otherwise it is the registered done state and
//                     the capture path alone folds in the CDB wakeup.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             op handshake (in_ready combinational)
//   in_microop, in_dest_arch,
//   in_dest_we                    incoming op and its destination
//   dec_microop, dec_rat_done,
//   dec_rat_aliases               to rename_decoder
//   dec_src_regs, dec_src_ready,
//   dec_immediate                 from rename_decoder
//   out_valid/out_ready           output handshake
//   out_microop, out_src_regs, out_src_ready, out_immediate,
//   out_dest_we, out_dest_tag, out_old_tag   renamed op
//   cdb_valid, cdb_tag            completion broadcast
//   free_valid, free_tag          tag returned at retire
// -----------------------------------------------------------------------------
module rename_ctrl
  import rename_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MOP_W-1:0]          in_microop,
  input  logic [ARCH_W-1:0]         in_dest_arch,
  input  logic                      in_dest_we,
  output logic [MOP_W-1:0]          dec_microop,
  output logic [NUM_ARCH-1:0]       dec_rat_done,
  output logic [NUM_ARCH*TAG_W-1:0] dec_rat_aliases,
  input  logic [NUM_SRC*TAG_W-1:0]  dec_src_regs,
  input  logic [NUM_SRC-1:0]        dec_src_ready,
  input  logic [IMM_W-1:0]          dec_immediate,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MOP_W-1:0]          out_microop,
  output logic [NUM_SRC*TAG_W-1:0]  out_src_regs,
  output logic [NUM_SRC-1:0]        out_src_ready,
  output logic [IMM_W-1:0]          out_immediate,
  output logic                      out_dest_we,
  output logic [TAG_W-1:0]          out_dest_tag,
  output logic [TAG_W-1:0]          out_old_tag,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic                      free_valid,
  input  logic [TAG_W-1:0]          free_tag
);

  state_t               state_r;
  logic [TAG_W-1:0]     init_tag_r;
  logic [TAG_W-1:0]     alias_r [NUM_ARCH];
  logic [NUM_ARCH-1:0]  done_r;

  logic                 run_s;
  logic                 cdb_hit_s;
  logic                 accept_s;
  logic                 alloc_s;
  logic                 dest_ok_s;
  logic [TAG_W-1:0]     old_tag_s;
  logic [NUM_ARCH-1:0]  cdb_arch_match_s;
  logic [NUM_SRC-1:0]   cap_ready_s;
  logic [NUM_SRC-1:0]   held_ready_s;
  logic                 fl_push_s;
  logic [TAG_W-1:0]     fl_push_tag_s;
  logic                 fl_pop_s;
  logic [TAG_W-1:0]     fl_head_s;
  logic [CNT_W-1:0]     fl_count_s;

  // Handshake, allocation decision and free-list port steering.
  always_comb begin
    run_s     = (state_r == ST_RUN);
    cdb_hit_s = cdb_valid & (cdb_tag != NULL_TAG);
    // Only writing ops need a free tag; others pass on an empty list.
    in_ready  = run_s & (~out_valid | out_ready)
              & (~in_dest_we | (fl_count_s != EMPTY_COUNT));
    accept_s  = in_valid & in_ready;
    alloc_s   = accept_s & in_dest_we;
    fl_pop_s  = alloc_s;
    dest_ok_s = (in_dest_arch < ARCH_W'(NUM_ARCH));
    if (dest_ok_s) begin
      old_tag_s = alias_r[in_dest_arch];
    end else begin
      old_tag_s = NULL_TAG;
    end
    // INIT owns the push port for seeding; retire frees are ignored there.
    if (run_s) begin
      fl_push_s     = free_valid;
      fl_push_tag_s = free_tag;
    end else begin
      fl_push_s     = 1'b1;
      fl_push_tag_s = init_tag_r;
    end
  end

  // CDB tag matches against the RAT, the decoder result and the held entry.
  always_comb begin
    cdb_arch_match_s = {NUM_ARCH{1'b0}};
    cap_ready_s      = {NUM_SRC{1'b0}};
    held_ready_s     = {NUM_SRC{1'b0}};
    for (int a = 0; a < NUM_ARCH; a++) begin
      cdb_arch_match_s[a] = cdb_hit_s & (alias_r[a] == cdb_tag);
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      cap_ready_s[k]  = dec_src_ready[k]
                      | (cdb_hit_s & (dec_src_regs[k*TAG_W +: TAG_W] == cdb_tag));
      held_ready_s[k] = out_src_ready[k]
                      | (cdb_hit_s & (out_src_regs[k*TAG_W +: TAG_W] == cdb_tag));
    end
  end

  // RAT view presented to rename_decoder.
  always_comb begin
    dec_microop     = in_microop;
    dec_rat_aliases = {(NUM_ARCH*TAG_W){1'b0}};
    for (int a = 0; a < NUM_ARCH; a++) begin
      dec_rat_aliases[a*TAG_W +: TAG_W] = alias_r[a];
    end
`ifdef RENAME_BYPASS_EN
    dec_rat_done = done_r | cdb_arch_match_s;
`else
    dec_rat_done = done_r;
`endif
  end

  // INIT/RUN sequencer; INIT walks the seeding counter up to the last tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_tag_r <= FIRST_FREE_TAG;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_tag_r <= init_tag_r + 5'd1;
          if (init_tag_r == LAST_TAG) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r    <= ST_INIT;
          init_tag_r <= FIRST_FREE_TAG;
        end
      endcase
    end
  end

  // RAT update; a same-cycle rename of an arch reg overrides its CDB wakeup.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        alias_r[a] <= reset_alias(a);
      end
      done_r <= {NUM_ARCH{1'b1}};
    end else begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        if (alloc_s && dest_ok_s && (in_dest_arch == ARCH_W'(a))) begin
          alias_r[a] <= fl_head_s;
          done_r[a]  <= 1'b0;
        end else if (cdb_arch_match_s[a]) begin
          done_r[a] <= 1'b1;
        end
      end
    end
  end

  // Output stage: load on accept, wake sources while held, clear on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_microop   <= {MOP_W{1'b0}};
      out_src_regs  <= {(NUM_SRC*TAG_W){1'b0}};
      out_src_ready <= {NUM_SRC{1'b0}};
      out_immediate <= {IMM_W{1'b0}};
      out_dest_we   <= 1'b0;
      out_dest_tag  <= NULL_TAG;
      out_old_tag   <= NULL_TAG;
    end else if (accept_s) begin
      out_valid     <= 1'b1;
      out_microop   <= in_microop;
      out_src_regs  <= dec_src_regs;
      out_src_ready <= cap_ready_s;
      out_immediate <= dec_immediate;
      out_dest_we   <= in_dest_we;
      out_dest_tag  <= in_dest_we ? fl_head_s : NULL_TAG;
      out_old_tag   <= in_dest_we ? old_tag_s : NULL_TAG;
    end else if (out_valid && !out_ready) begin
      out_src_ready <= held_ready_s;
    end else begin
      out_valid     <= 1'b0;
      out_microop   <= {MOP_W{1'b0}};
      out_src_regs  <= {(NUM_SRC*TAG_W){1'b0}};
      out_src_ready <= {NUM_SRC{1'b0}};
      out_immediate <= {IMM_W{1'b0}};
      out_dest_we   <= 1'b0;
      out_dest_tag  <= NULL_TAG;
      out_old_tag   <= NULL_TAG;
    end
  end

  free_list_fifo u_free_list (
    .clk      (clk),
    .rst      (rst),
    .push     (fl_push_s),
    .push_tag (fl_push_tag_s),
    .pop      (fl_pop_s),
    .head_tag (fl_head_s),
    .count    (fl_count_s)
  );

endmodule

// File: tb/tb_rename_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rename_ctrl
//   Bench for rename_ctrl. A small rename_decoder stand-in maps micro-op
//   nibbles [4k+3:4k] (mod NUM_ARCH) to source arch regs and bits [19:16] to
//   the immediate. A behavioural model (arrays + a tag queue) predicts every
//   output; one process compares them on each falling edge. Directed sections
//   pin the model with literal values, then a randomized phase follows.
//   Honours RENAME_BYPASS_EN for the expected dec_rat_done.
// -----------------------------------------------------------------------------
module tb_rename_ctrl;
  import rename_ctrl_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [MOP_W-1:0]          in_microop;
  logic [ARCH_W-1:0]         in_dest_arch;
  logic                      in_dest_we;
  logic [MOP_W-1:0]          dec_microop;
  logic [NUM_ARCH-1:0]       dec_rat_done;
  logic [NUM_ARCH*TAG_W-1:0] dec_rat_aliases;
  logic [NUM_SRC*TAG_W-1:0]  dec_src_regs;
  logic [NUM_SRC-1:0]        dec_src_ready;
  logic [IMM_W-1:0]          dec_immediate;
  logic                      out_valid;
  logic                      out_ready;
  logic [MOP_W-1:0]          out_microop;
  logic [NUM_SRC*TAG_W-1:0]  out_src_regs;
  logic [NUM_SRC-1:0]        out_src_ready;
  logic [IMM_W-1:0]          out_immediate;
  logic                      out_dest_we;
  logic [TAG_W-1:0]          out_dest_tag;
  logic [TAG_W-1:0]          out_old_tag;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic                      free_valid;
  logic [TAG_W-1:0]          free_tag;

  always #5 clk = ~clk;

  rename_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_microop(in_microop),
    .in_dest_arch(in_dest_arch), .in_dest_we(in_dest_we),
    .dec_microop(dec_microop), .dec_rat_done(dec_rat_done),
    .dec_rat_aliases(dec_rat_aliases), .dec_src_regs(dec_src_regs),
    .dec_src_ready(dec_src_ready), .dec_immediate(dec_immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_microop(out_microop),
    .out_src_regs(out_src_regs), .out_src_ready(out_src_ready),
    .out_immediate(out_immediate), .out_dest_we(out_dest_we),
    .out_dest_tag(out_dest_tag), .out_old_tag(out_old_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .free_valid(free_valid), .free_tag(free_tag)
  );

  // rename_decoder stand-in: look sources up in the RAT the DUT presents.
  int dec_arch;
  always_comb begin
    dec_src_regs  = '0;
    dec_src_ready = '0;
    dec_arch      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      dec_arch = int'(dec_microop[k*4 +: 4]) % NUM_ARCH;
      dec_src_regs[k*TAG_W +: TAG_W] = dec_rat_aliases[dec_arch*TAG_W +: TAG_W];
      dec_src_ready[k] = dec_rat_done[dec_arch];
    end
    dec_immediate = dec_microop[19:16];
  end

  // ---------------- behavioural model ----------------
  int       m_alias [NUM_ARCH];
  bit       m_done  [NUM_ARCH];
  int       fq[$];
  int       retire_pool[$];
  int       init_next;
  bit       m_run;
  bit       mo_valid;
  bit [23:0] mo_uop;
  int       mo_src [NUM_SRC];
  bit       mo_rdy [NUM_SRC];
  int       mo_imm;
  bit       mo_we;
  int       mo_dt;
  int       mo_ot;
  bit       chk_en = 1'b0;
  int       n_chk  = 0;
  int       n_pass = 0;

  function automatic bit cdb_hits(int t);
    return cdb_valid && (cdb_tag != 5'd0) && (int'(cdb_tag) == t);
  endfunction

  function automatic bit exp_ready();
    return m_run && (!mo_valid || out_ready) && (!in_dest_we || fq.size() != 0);
  endfunction

  function automatic int src_arch(bit [23:0] u, int k);
    return int'(u[k*4 +: 4]) % NUM_ARCH;
  endfunction

  task automatic clear_out();
    mo_valid = 1'b0; mo_uop = 24'd0; mo_imm = 0; mo_we = 1'b0; mo_dt = 0; mo_ot = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      mo_src[k] = 0; mo_rdy[k] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    bit acc;
    bit we;
    int head;
    int d;
    if (rst) begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        m_alias[a] = a + 1; m_done[a] = 1'b1;
      end
      fq.delete(); retire_pool.delete();
      init_next = NUM_ARCH + 1; m_run = 1'b0;
      clear_out();
      chk_en = 1'b1;
      return;
    end
    acc  = in_valid && exp_ready();
    we   = in_dest_we;
    d    = int'(in_dest_arch);
    head = (fq.size() != 0) ? fq[0] : 0;
    if (mo_valid && out_ready && mo_we) retire_pool.push_back(mo_ot);
    if (acc) begin
      mo_valid = 1'b1; mo_uop = in_microop; mo_imm = int'(in_microop[19:16]);
      for (int k = 0; k < NUM_SRC; k++) begin
        mo_src[k] = m_alias[src_arch(in_microop, k)];
        mo_rdy[k] = m_done[src_arch(in_microop, k)] || cdb_hits(mo_src[k]);
      end
      mo_we = we;
      mo_dt = we ? head : 0;
      mo_ot = we ? m_alias[d] : 0;
    end else if (mo_valid && !out_ready) begin
      for (int k = 0; k < NUM_SRC; k++) mo_rdy[k] = mo_rdy[k] || cdb_hits(mo_src[k]);
    end else begin
      clear_out();
    end
    for (int a = 0; a < NUM_ARCH; a++) if (cdb_hits(m_alias[a])) m_done[a] = 1'b1;
    if (acc && we) begin
      m_alias[d] = head; m_done[d] = 1'b0; void'(fq.pop_front());
    end
    if (!m_run) begin
      fq.push_back(init_next);
      init_next++;
      if (init_next >= NUM_PHYS) m_run = 1'b1;
    end else if (free_valid) begin
      fq.push_back(int'(free_tag));
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare every output against the model on each falling edge.
  logic [NUM_ARCH*TAG_W-1:0] e_alias;
  logic [NUM_ARCH-1:0]       e_done;
  logic [NUM_SRC*TAG_W-1:0]  e_src;
  logic [NUM_SRC-1:0]        e_rdy;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        e_alias[a*TAG_W +: TAG_W] = TAG_W'(m_alias[a]);
`ifdef RENAME_BYPASS_EN
        e_done[a] = m_done[a] || cdb_hits(m_alias[a]);
`else
        e_done[a] = m_done[a];
`endif
      end
      for (int k = 0; k < NUM_SRC; k++) begin
        e_src[k*TAG_W +: TAG_W] = TAG_W'(mo_src[k]);
        e_rdy[k] = mo_rdy[k];
      end
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("dec_microop", 64'(dec_microop), 64'(in_microop));
      chk("dec_rat_aliases", 64'(dec_rat_aliases), 64'(e_alias));
      chk("dec_rat_done", 64'(dec_rat_done), 64'(e_done));
      chk("out_valid", 64'(out_valid), 64'(mo_valid));
      chk("out_microop", 64'(out_microop), 64'(mo_uop));
      chk("out_src_regs", 64'(out_src_regs), 64'(e_src));
      chk("out_src_ready", 64'(out_src_ready), 64'(e_rdy));
      chk("out_immediate", 64'(out_immediate), 64'(mo_imm));
      chk("out_dest_we", 64'(out_dest_we), 64'(mo_we));
      chk("out_dest_tag", 64'(out_dest_tag), 64'(mo_dt));
      chk("out_old_tag", 64'(out_old_tag), 64'(mo_ot));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(bit v, bit [23:0] u, int dest, bit we);
    in_valid = v; in_microop = u; in_dest_arch = ARCH_W'(dest); in_dest_we = we;
  endtask

  logic [NUM_ARCH*TAG_W-1:0] reset_aliases;

  initial begin
    reset_aliases = {5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    rst = 1'b1; out_ready = 1'b1; cdb_valid = 1'b0; cdb_tag = 5'd0;
    free_valid = 1'b0; free_tag = 5'd0;
    set_op(1'b0, 24'd0, 0, 1'b1);
    step(); step();
    rst = 1'b0;

    // Seeding: 21 cycles with in_ready low, then high.
    for (int i = 0; i < 21; i++) begin
      chk("init_ready_low", 64'(in_ready), 64'd0);
      step();
    end
    chk("init_ready_high", 64'(in_ready), 64'd1);
    chk("reset_aliases", 64'(dec_rat_aliases), 64'(reset_aliases));
    chk("reset_done", 64'(dec_rat_done), 64'h3FF);

    // First write to arch 3.
    set_op(1'b1, 24'h000000, 3, 1'b1); step();
    chk("wr1_dest_tag", 64'(out_dest_tag), 64'h0B);
    chk("wr1_old_tag", 64'(out_old_tag), 64'h04);
    chk("wr1_done3", 64'(dec_rat_done[3]), 64'd0);

    // Reader of arch 3 while tag 0B completes on the CDB.
    set_op(1'b1, 24'h000003, 0, 1'b0); cdb_valid = 1'b1; cdb_tag = 5'h0B; #1;
`ifdef RENAME_BYPASS_EN
    chk("bypass_done3", 64'(dec_rat_done[3]), 64'd1);
`else
    chk("bypass_done3", 64'(dec_rat_done[3]), 64'd0);
`endif
    step();
    cdb_valid = 1'b0;
    chk("cap_src0_tag", 64'(out_src_regs[4:0]), 64'h0B);
    chk("cap_src0_ready", 64'(out_src_ready[0]), 64'd1);

    // Second write to arch 3.
    set_op(1'b1, 24'h000000, 3, 1'b1); step();
    chk("wr2_dest_tag", 64'(out_dest_tag), 64'h0C);
    chk("wr2_old_tag", 64'(out_old_tag), 64'h0B);

    // CDB of arch 3's current tag in the same cycle arch 3 is renamed.
    set_op(1'b1, 24'h000000, 3, 1'b1); cdb_valid = 1'b1; cdb_tag = 5'h0C; step();
    cdb_valid = 1'b0;
    chk("race_done3", 64'(dec_rat_done[3]), 64'd0);
    chk("race_alias3", 64'(dec_rat_aliases[19:15]), 64'h0D);

    // Drain the remaining 18 free tags.
    for (int i = 0; i < 18; i++) begin
      set_op(1'b1, 24'h000000, 5, 1'b1); step();
    end
    chk("exhaust_last", 64'(out_dest_tag), 64'h1F);
    set_op(1'b1, 24'h000000, 5, 1'b1); #1;
    chk("empty_writer_ready", 64'(in_ready), 64'd0);
    set_op(1'b1, 24'h000000, 5, 1'b0); #1;
    chk("empty_reader_ready", 64'(in_ready), 64'd1);
    set_op(1'b0, 24'h000000, 5, 1'b0); free_valid = 1'b1; free_tag = 5'h04; step();
    free_valid = 1'b0;
    set_op(1'b1, 24'h000000, 7, 1'b1); step();
    chk("refree_dest_tag", 64'(out_dest_tag), 64'h04);

    // Backpressure: hold an op reading arch 5 (tag 1F, not done).
    set_op(1'b1, 24'h035005, 0, 1'b0); step();
    chk("held_src0_ready0", 64'(out_src_ready[0]), 64'd0);
    out_ready = 1'b0;
    set_op(1'b1, 24'h000001, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("held_in_ready", 64'(in_ready), 64'd0);
      cdb_valid = (i == 1); cdb_tag = 5'h1F;
      step();
      chk("held_microop", 64'(out_microop), 64'h035005);
      chk("held_valid", 64'(out_valid), 64'd1);
    end
    cdb_valid = 1'b0;
    chk("held_src0_woken", 64'(out_src_ready[0]), 64'd1);
    out_ready = 1'b1; set_op(1'b0, 24'd0, 0, 1'b0); step();
    chk("release_valid", 64'(out_valid), 64'd0);

    // Reset while an op is being accepted.
    set_op(1'b1, 24'h000000, 1, 1'b1); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      set_op($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, NUM_ARCH - 1),
             $urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < 7);
      cdb_valid  = ($urandom_range(0, 9) < 4);
      cdb_tag    = TAG_W'($urandom_range(0, NUM_PHYS - 1));
      free_valid = 1'b0; free_tag = 5'd0;
      if (m_run && retire_pool.size() != 0 && $urandom_range(0, 9) < 3) begin
        free_valid = 1'b1;
        free_tag   = TAG_W'(retire_pool.pop_front());
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
